// File: rtl/serial_word_transmitter_msb_first_if.sv
// Word-in / bit-out bundle for serial_word_transmitter_msb_first.
// SERIAL_WORD_TX_MOD5_EN adds the running mod-5 remainder outputs.
interface serial_word_transmitter_msb_first_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_bit;
  logic             out_first;
  logic             out_last;
`ifdef SERIAL_WORD_TX_MOD5_EN
  logic [2:0]       rem5;
  logic             div_by_5;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_bit, out_first, out_last,
    input  rem5, div_by_5
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_bit, out_first, out_last,
    output rem5, div_by_5
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_bit, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_bit, out_first, out_last
  );
`endif
endinterface

// File: rtl/serial_word_transmitter_msb_first.sv
// Parallel-to-serial word source, MSB first, with first/last framing.
// Optional SERIAL_WORD_TX_MOD5_EN adds a golden mod-5 remainder.
module serial_word_transmitter_msb_first #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_word_transmitter_msb_first_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_valid;
  logic             r_bit;
  logic             r_first;
  logic             r_last;

  logic w_ready;
  logic w_hs;
  logic w_more;

  // Ready only while idle or on the final bit, so a new word follows
  // the current LSB with no bubble.
  assign w_ready = rst & ((r_state == S_IDLE) | (r_cnt == '0));
  assign w_hs    = bus.in_valid & w_ready;
  assign w_more  = (r_state == S_SEND) & (r_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_bit   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_hs) begin
      r_state <= S_SEND;
      r_cnt   <= CNT_LOAD;
      r_shift <= bus.in_data;
      r_valid <= 1'b1;
      r_bit   <= bus.in_data[WIDTH-1];
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else if (w_more) begin
      r_cnt   <= r_cnt - CNT_ONE;
      r_shift <= r_shift << 1;
      r_valid <= 1'b1;
      r_bit   <= r_shift[WIDTH-2];
      r_first <= 1'b0;
      r_last  <= (r_cnt == CNT_ONE);
    end else begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_bit   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_bit   = r_bit;
  assign bus.out_first = r_first;
  assign bus.out_last  = r_last;

`ifdef SERIAL_WORD_TX_MOD5_EN
  logic [2:0] r_rem5;
  logic [3:0] w_rem_dbl;
  logic [2:0] w_rem_nxt;

  // Value of the bits sent so far, mod 5; 2*r+b never exceeds 9.
  assign w_rem_dbl = {r_rem5, 1'b0} + {3'b000, r_shift[WIDTH-2]};
  assign w_rem_nxt = (w_rem_dbl >= 4'd5) ? 3'(w_rem_dbl - 4'd5)
                                         : w_rem_dbl[2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem5 <= 3'd0;
    end else if (w_hs) begin
      r_rem5 <= {2'b00, bus.in_data[WIDTH-1]};
    end else if (w_more) begin
      r_rem5 <= w_rem_nxt;
    end
  end

  assign bus.rem5     = r_rem5;
  assign bus.div_by_5 = r_valid & (r_rem5 == 3'd0);
`endif
endmodule
